// File: rtl/cv32e40p_rf_err_pkg.sv
// ============================================================================
// cv32e40p_rf_err_pkg : shared types and constants for the RF error monitor
// Revision: 1.0
// ============================================================================
`default_nettype none

package cv32e40p_rf_err_pkg;

  typedef enum logic [1:0] {
    SCRUB_IDLE = 2'd0,
    SCRUB_WAIT = 2'd1,
    SCRUB_REQ  = 2'd2
  } scrub_state_e;

  localparam logic [1:0] PORT_A     = 2'd0;
  localparam logic [1:0] PORT_B     = 2'd1;
  localparam logic [1:0] PORT_C     = 2'd2;
  localparam logic [1:0] PORT_SCRUB = 2'd3;

  function automatic logic [1:0] count3(input logic [2:0] v);
    return {1'b0, v[0]} + {1'b0, v[1]} + {1'b0, v[2]};
  endfunction

endpackage

`default_nettype wire

// File: rtl/cv32e40p_rf_scrub_fsm.sv
// ============================================================================
// cv32e40p_rf_scrub_fsm : background scrub sequencer borrowing RF read port C
// Revision: 1.0
// ============================================================================
`default_nettype none

module cv32e40p_rf_scrub_fsm
  import cv32e40p_rf_err_pkg::*;
#(
  parameter int ADDR_WIDTH     = 6,
  parameter int NUM_TOT_WORDS  = 64,
  parameter int SCRUB_INTERVAL = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  scrub_en_i,
  input  logic                  scrub_gnt_i,
  output logic                  scrub_req_o,
  output logic [ADDR_WIDTH-1:0] scrub_addr_o
);

  localparam logic [7:0]            RELOAD    = 8'(SCRUB_INTERVAL - 1);
  localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(NUM_TOT_WORDS - 1);

  scrub_state_e          state;
  logic [7:0]            interval_cnt;
  logic [ADDR_WIDTH-1:0] addr;

  // Disable has priority everywhere; the address is kept so scrubbing resumes
  // where it stopped.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= SCRUB_IDLE;
      interval_cnt <= '0;
      addr         <= '0;
    end else if (!scrub_en_i) begin
      state <= SCRUB_IDLE;
    end else begin
      case (state)
        SCRUB_IDLE: begin
          state        <= SCRUB_WAIT;
          interval_cnt <= RELOAD;
        end
        SCRUB_WAIT: begin
          if (interval_cnt == 8'd0) begin
            state <= SCRUB_REQ;
          end else begin
            interval_cnt <= interval_cnt - 8'd1;
          end
        end
        SCRUB_REQ: begin
          if (scrub_gnt_i) begin
            addr         <= (addr == LAST_ADDR) ? '0 : addr + 1'b1;
            state        <= SCRUB_WAIT;
            interval_cnt <= RELOAD;
          end
        end
        default: state <= SCRUB_IDLE;
      endcase
    end
  end

  assign scrub_req_o  = (state == SCRUB_REQ);
  assign scrub_addr_o = addr;

endmodule

`default_nettype wire

// File: rtl/cv32e40p_rf_err_monitor.sv
// ============================================================================
// cv32e40p_rf_err_monitor : logs register-file parity errors and scrubs the RF
// Revision: 1.0
// ============================================================================
`default_nettype none

module cv32e40p_rf_err_monitor
  import cv32e40p_rf_err_pkg::*;
#(
  parameter int ADDR_WIDTH     = 6,
  parameter int NUM_TOT_WORDS  = 64,
  parameter int SCRUB_INTERVAL = 16,
  parameter int IRQ_THRESH     = 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [ADDR_WIDTH-1:0] raddr_a_i,
  input  logic [ADDR_WIDTH-1:0] raddr_b_i,
  input  logic [ADDR_WIDTH-1:0] raddr_c_i,
  input  logic [2:0]            rvalid_i,
  input  logic [2:0]            parity_ok_i,
  input  logic                  scrub_en_i,
  output logic                  scrub_req_o,
  output logic [ADDR_WIDTH-1:0] scrub_addr_o,
  input  logic                  scrub_gnt_i,
  input  logic                  err_clr_i,
  output logic                  err_valid_o,
  output logic [ADDR_WIDTH-1:0] err_addr_o,
  output logic [1:0]            err_port_o,
  output logic [7:0]            err_cnt_o,
  output logic                  err_irq_o
);

  cv32e40p_rf_scrub_fsm #(
    .ADDR_WIDTH     (ADDR_WIDTH),
    .NUM_TOT_WORDS  (NUM_TOT_WORDS),
    .SCRUB_INTERVAL (SCRUB_INTERVAL)
  ) u_scrub_fsm (
    .clk          (clk),
    .rst_n        (rst_n),
    .scrub_en_i   (scrub_en_i),
    .scrub_gnt_i  (scrub_gnt_i),
    .scrub_req_o  (scrub_req_o),
    .scrub_addr_o (scrub_addr_o)
  );

  logic                  scrub_evt;
  logic [2:0]            evt;
  logic [1:0]            evt_num;
  logic [8:0]            cnt_sum;
  logic [7:0]            cnt_next;
  logic [1:0]            first_port;
  logic [ADDR_WIDTH-1:0] first_addr;

  // A scrub error occupies the port-C slot; it is still a single event.
  assign scrub_evt = scrub_req_o & scrub_gnt_i & ~parity_ok_i[2];
  assign evt[0]    = rvalid_i[0] & ~parity_ok_i[0];
  assign evt[1]    = rvalid_i[1] & ~parity_ok_i[1];
  assign evt[2]    = scrub_evt | (rvalid_i[2] & ~parity_ok_i[2]);
  assign evt_num   = count3(evt);
  assign cnt_sum   = {1'b0, err_cnt_o} + {7'd0, evt_num};
  assign cnt_next  = cnt_sum[8] ? 8'hFF : cnt_sum[7:0];

  always_comb begin
    first_port = PORT_A;
    first_addr = raddr_a_i;
    if (evt[0]) begin
      first_port = PORT_A;
      first_addr = raddr_a_i;
    end else if (evt[1]) begin
      first_port = PORT_B;
      first_addr = raddr_b_i;
    end else if (scrub_evt) begin
      first_port = PORT_SCRUB;
      first_addr = scrub_addr_o;
    end else begin
      first_port = PORT_C;
      first_addr = raddr_c_i;
    end
  end

  // On clear, an event in the same cycle becomes the first entry of a fresh log.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_valid_o <= 1'b0;
      err_addr_o  <= '0;
      err_port_o  <= PORT_A;
      err_cnt_o   <= 8'd0;
    end else if (err_clr_i) begin
      err_cnt_o   <= {6'd0, evt_num};
      err_valid_o <= |evt;
      err_addr_o  <= (|evt) ? first_addr : '0;
      err_port_o  <= (|evt) ? first_port : PORT_A;
    end else begin
      err_cnt_o <= cnt_next;
      if (!err_valid_o && (|evt)) begin
        err_valid_o <= 1'b1;
        err_addr_o  <= first_addr;
        err_port_o  <= first_port;
      end
    end
  end

  assign err_irq_o = (err_cnt_o >= 8'(IRQ_THRESH));

endmodule

`default_nettype wire

// File: tb/tb_cv32e40p_rf_err_monitor.sv
// ============================================================================
// tb_cv32e40p_rf_err_monitor : directed self-checking bench for the RF monitor
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_cv32e40p_rf_err_monitor;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [5:0] raddr_a_i, raddr_b_i, raddr_c_i;
  logic [2:0] rvalid_i, parity_ok_i;
  logic       scrub_en_i, scrub_gnt_i, err_clr_i;
  logic       scrub_req_o;
  logic [5:0] scrub_addr_o;
  logic       err_valid_o;
  logic [5:0] err_addr_o;
  logic [1:0] err_port_o;
  logic [7:0] err_cnt_o;
  logic       err_irq_o;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  cv32e40p_rf_err_monitor #(
    .ADDR_WIDTH     (6),
    .NUM_TOT_WORDS  (64),
    .SCRUB_INTERVAL (4),
    .IRQ_THRESH     (1)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .raddr_a_i    (raddr_a_i),
    .raddr_b_i    (raddr_b_i),
    .raddr_c_i    (raddr_c_i),
    .rvalid_i     (rvalid_i),
    .parity_ok_i  (parity_ok_i),
    .scrub_en_i   (scrub_en_i),
    .scrub_req_o  (scrub_req_o),
    .scrub_addr_o (scrub_addr_o),
    .scrub_gnt_i  (scrub_gnt_i),
    .err_clr_i    (err_clr_i),
    .err_valid_o  (err_valid_o),
    .err_addr_o   (err_addr_o),
    .err_port_o   (err_port_o),
    .err_cnt_o    (err_cnt_o),
    .err_irq_o    (err_irq_o)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    rvalid_i    = 3'b000;
    parity_ok_i = 3'b111;
    err_clr_i   = 1'b0;
  endtask

  task automatic do_clear();
    idle_inputs();
    err_clr_i = 1'b1;
    step();
    err_clr_i = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; raddr_a_i = '0; raddr_b_i = '0; raddr_c_i = '0;
    scrub_en_i = 1'b0; scrub_gnt_i = 1'b0;
    idle_inputs();
    #12;
    checks++;
    if ({scrub_req_o, scrub_addr_o, err_valid_o, err_addr_o, err_port_o, err_cnt_o, err_irq_o} !== '0) begin
      errors++;
      $display("FAIL reset: req=%0b saddr=%0d valid=%0b addr=%0d port=%0d cnt=%0d irq=%0b, all required 0",
               scrub_req_o, scrub_addr_o, err_valid_o, err_addr_o, err_port_o, err_cnt_o, err_irq_o);
    end
    @(negedge clk);
    rst_n = 1'b1;
    step();
  endtask

  task automatic test_first_error();
    rvalid_i = 3'b001; parity_ok_i = 3'b110; raddr_a_i = 6'd5;
    step();
    idle_inputs();
    checks++;
    if ({err_valid_o, err_addr_o, err_port_o, err_cnt_o, err_irq_o} !== {1'b1, 6'd5, 2'd0, 8'd1, 1'b1}) begin
      errors++;
      $display("FAIL first_error: valid=%0b addr=%0d port=%0d cnt=%0d irq=%0b, required 1/5/0/1/1",
               err_valid_o, err_addr_o, err_port_o, err_cnt_o, err_irq_o);
    end
  endtask

  task automatic test_multi_event();
    rvalid_i = 3'b111; parity_ok_i = 3'b000; raddr_b_i = 6'd9; raddr_c_i = 6'd7;
    step();
    idle_inputs();
    checks++;
    if ({err_cnt_o, err_addr_o, err_port_o} !== {8'd4, 6'd5, 2'd0}) begin
      errors++;
      $display("FAIL multi_event: cnt=%0d addr=%0d port=%0d, required 4/5/0", err_cnt_o, err_addr_o, err_port_o);
    end
    // parity errors on ports that are not consumed are not events
    rvalid_i = 3'b000; parity_ok_i = 3'b000;
    step();
    idle_inputs();
    checks++;
    if (err_cnt_o !== 8'd4) begin
      errors++;
      $display("FAIL no_rvalid: cnt=%0d, required 4", err_cnt_o);
    end
  endtask

  task automatic test_clear_collision();
    err_clr_i = 1'b1; rvalid_i = 3'b010; parity_ok_i = 3'b101; raddr_b_i = 6'd12;
    step();
    idle_inputs();
    checks++;
    if ({err_valid_o, err_cnt_o, err_addr_o, err_port_o} !== {1'b1, 8'd1, 6'd12, 2'd1}) begin
      errors++;
      $display("FAIL clear_collision: valid=%0b cnt=%0d addr=%0d port=%0d, required 1/1/12/1",
               err_valid_o, err_cnt_o, err_addr_o, err_port_o);
    end
    do_clear();
    checks++;
    if ({err_valid_o, err_cnt_o, err_addr_o, err_port_o, err_irq_o} !== '0) begin
      errors++;
      $display("FAIL clear: valid=%0b cnt=%0d addr=%0d port=%0d irq=%0b, required all 0",
               err_valid_o, err_cnt_o, err_addr_o, err_port_o, err_irq_o);
    end
  endtask

  task automatic test_port_priority();
    rvalid_i = 3'b110; parity_ok_i = 3'b000; raddr_b_i = 6'd3; raddr_c_i = 6'd4;
    step();
    idle_inputs();
    checks++;
    if ({err_cnt_o, err_addr_o, err_port_o} !== {8'd2, 6'd3, 2'd1}) begin
      errors++;
      $display("FAIL priority_bc: cnt=%0d addr=%0d port=%0d, required 2/3/1", err_cnt_o, err_addr_o, err_port_o);
    end
    do_clear();
    rvalid_i = 3'b100; parity_ok_i = 3'b011; raddr_c_i = 6'd44;
    step();
    idle_inputs();
    checks++;
    if ({err_cnt_o, err_addr_o, err_port_o} !== {8'd1, 6'd44, 2'd2}) begin
      errors++;
      $display("FAIL port_c: cnt=%0d addr=%0d port=%0d, required 1/44/2", err_cnt_o, err_addr_o, err_port_o);
    end
  endtask

  task automatic test_saturation();
    do_clear();
    rvalid_i = 3'b111; parity_ok_i = 3'b000;
    repeat (84) step();
    rvalid_i = 3'b011;
    step();
    checks++;
    if (err_cnt_o !== 8'd254) begin
      errors++;
      $display("FAIL sat_254: cnt=%0d, required 254", err_cnt_o);
    end
    rvalid_i = 3'b111;
    step();
    checks++;
    if (err_cnt_o !== 8'd255) begin
      errors++;
      $display("FAIL sat_255: cnt=%0d, required 255", err_cnt_o);
    end
    step();
    idle_inputs();
    checks++;
    if ({err_cnt_o, err_irq_o} !== {8'd255, 1'b1}) begin
      errors++;
      $display("FAIL sat_hold: cnt=%0d irq=%0b, required 255/1", err_cnt_o, err_irq_o);
    end
  endtask

  task automatic test_scrub_sweep();
    int         since;
    int         pulses;
    logic [5:0] exp_addr;
    do_clear();
    since = 0; pulses = 0; exp_addr = 6'd0;
    scrub_en_i = 1'b1; scrub_gnt_i = 1'b1;
    for (int cyc = 0; cyc < 400 && pulses < 65; cyc++) begin
      step();
      since++;
      parity_ok_i = 3'b111;
      if (scrub_req_o) begin
        checks++;
        if (scrub_addr_o !== exp_addr || since != 5) begin
          errors++;
          $display("FAIL scrub_pulse%0d: addr=%0d gap=%0d, required addr=%0d gap=5",
                   pulses, scrub_addr_o, since, exp_addr);
        end
        if (exp_addr == 6'd63) parity_ok_i[2] = 1'b0;
        exp_addr = (exp_addr == 6'd63) ? 6'd0 : exp_addr + 6'd1;
        pulses++;
        since = 0;
      end
    end
    checks++;
    if (pulses != 65) begin
      errors++;
      $display("FAIL scrub_timeout: pulses=%0d, required 65", pulses);
    end
    checks++;
    if ({err_valid_o, err_port_o, err_addr_o, err_cnt_o} !== {1'b1, 2'd3, 6'd63, 8'd1}) begin
      errors++;
      $display("FAIL scrub_error: valid=%0b port=%0d addr=%0d cnt=%0d, required 1/3/63/1",
               err_valid_o, err_port_o, err_addr_o, err_cnt_o);
    end
    step();
    scrub_en_i = 1'b0;
    step();
    checks++;
    if ({scrub_req_o, scrub_addr_o} !== {1'b0, 6'd1}) begin
      errors++;
      $display("FAIL scrub_stop: req=%0b addr=%0d, required 0/1", scrub_req_o, scrub_addr_o);
    end
  endtask

  task automatic test_gnt_withheld();
    int waited;
    scrub_gnt_i = 1'b0; scrub_en_i = 1'b1;
    waited = 0;
    while (!scrub_req_o && waited < 20) begin
      step();
      waited++;
    end
    checks++;
    if (waited != 5) begin
      errors++;
      $display("FAIL withheld_latency: cycles=%0d, required 5", waited);
    end
    for (int i = 0; i < 10; i++) begin
      step();
      checks++;
      if ({scrub_req_o, scrub_addr_o} !== {1'b1, 6'd1}) begin
        errors++;
        $display("FAIL withheld_hold%0d: req=%0b addr=%0d, required 1/1", i, scrub_req_o, scrub_addr_o);
      end
    end
    scrub_en_i = 1'b0;
    step();
    checks++;
    if ({scrub_req_o, scrub_addr_o} !== {1'b0, 6'd1}) begin
      errors++;
      $display("FAIL withheld_disable: req=%0b addr=%0d, required 0/1", scrub_req_o, scrub_addr_o);
    end
    scrub_gnt_i = 1'b1;
    repeat (3) step();
    checks++;
    if ({scrub_req_o, scrub_addr_o} !== {1'b0, 6'd1}) begin
      errors++;
      $display("FAIL stray_gnt: req=%0b addr=%0d, required 0/1", scrub_req_o, scrub_addr_o);
    end
    scrub_gnt_i = 1'b0;
  endtask

  task automatic test_async_reset();
    int waited;
    scrub_en_i = 1'b1; scrub_gnt_i = 1'b0;
    waited = 0;
    while (!scrub_req_o && waited < 20) begin
      step();
      waited++;
    end
    parity_ok_i = 3'b011; scrub_gnt_i = 1'b1;
    #2;
    rst_n = 1'b0;
    #1;
    checks++;
    if ({waited == 5, scrub_req_o, scrub_addr_o, err_cnt_o} !== {1'b1, 1'b0, 6'd0, 8'd0}) begin
      errors++;
      $display("FAIL async_reset: wait=%0d req=%0b addr=%0d cnt=%0d, required 5/0/0/0",
               waited, scrub_req_o, scrub_addr_o, err_cnt_o);
    end
    scrub_en_i = 1'b0; scrub_gnt_i = 1'b0;
    idle_inputs();
    @(negedge clk);
    rst_n = 1'b1;
    step();
    checks++;
    if ({err_valid_o, err_cnt_o, scrub_req_o} !== '0) begin
      errors++;
      $display("FAIL reset_gnt_dropped: valid=%0b cnt=%0d req=%0b, required 0/0/0",
               err_valid_o, err_cnt_o, scrub_req_o);
    end
  endtask

  initial begin
    test_reset();
    test_first_error();
    test_multi_event();
    test_clear_collision();
    test_port_priority();
    test_saturation();
    test_scrub_sweep();
    test_gnt_withheld();
    test_async_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/cv32e40p_rf_err_monitor.md
CV32E40P_RF_ERR_MONITOR -- requirements
Module: cv32e40p_rf_err_monitor

Interface
REQ-001 SHALL have parameter ADDR_WIDTH, default 6, register-file address width (bit 5 selects FP bank).
REQ-002 SHALL have parameter NUM_TOT_WORDS, default 64, number of addressable words to scrub.
REQ-003 SHALL have parameter SCRUB_INTERVAL, default 16, idle cycles between scrub requests (legal range 1..255).
REQ-004 SHALL have parameter IRQ_THRESH, default 1, error count at which err_irq_o asserts (legal range 1..255).
REQ-005 clk  input  1  clock, rising edge.
REQ-006 rst_n  input  1  reset, asynchronous, active-low.
REQ-007 raddr_a_i / raddr_b_i / raddr_c_i  input  ADDR_WIDTH each  read addresses presented to the register file this cycle.
REQ-008 rvalid_i  input  3  per-port flag (bit0=A, bit1=B, bit2=C): the core consumes that port's read this cycle.
REQ-009 parity_ok_i  input  3  per-port register-file status, 1 = stored parity consistent, 0 = parity error.
REQ-010 scrub_en_i  input  1  enables background scrubbing.
REQ-011 scrub_req_o  output  1  request to borrow read port C.
REQ-012 scrub_addr_o  output  ADDR_WIDTH  address to drive on port C while scrub_req_o=1.
REQ-013 scrub_gnt_i  input  1  port C driven with scrub_addr_o this cycle.
REQ-014 err_clr_i  input  1  clears error log.
REQ-015 err_valid_o  output  1  at least one error logged since last clear.
REQ-016 err_addr_o  output  ADDR_WIDTH  address of first logged error.
REQ-017 err_port_o  output  2  port of first logged error (0=A, 1=B, 2=C, 3=scrub).
REQ-018 err_cnt_o  output  8  saturating error count.
REQ-019 err_irq_o  output  1  level interrupt, err_cnt_o >= IRQ_THRESH.

Function
REQ-020 Error event per port p SHALL be e[p] = rvalid_i[p] & ~parity_ok_i[p]; scrub event = scrub_req_o & scrub_gnt_i & ~parity_ok_i[2], and when present it replaces e[2] (rvalid_i[2] ignored that cycle).
REQ-021 Events SHALL be sampled on the same clk edge as the read; all log outputs update one cycle after the faulty read.
REQ-022 err_cnt_o SHALL add the number of events in the cycle (0..3), saturating at 255, no wrap.
REQ-023 When err_valid_o=0 and any event occurs, SHALL capture lowest-indexed erroring port (A<B<C/scrub) and its address, set err_valid_o; when err_valid_o=1 capture SHALL be frozen.
REQ-024 err_clr_i SHALL zero err_cnt_o, err_valid_o, err_addr_o, err_port_o; an event in the same cycle SHALL win and be logged as first event after clear.
REQ-025 err_irq_o SHALL be registered-equivalent: high iff err_cnt_o >= IRQ_THRESH.
REQ-026 Scrub FSM states: IDLE, WAIT, REQ.
REQ-027 IDLE -> WAIT when scrub_en_i=1, loading interval counter with SCRUB_INTERVAL-1.
REQ-028 WAIT decrements counter each cycle; at 0 -> REQ.
REQ-029 REQ holds scrub_req_o=1 and stable scrub_addr_o until scrub_gnt_i=1; on grant, address increments and FSM -> WAIT with counter reloaded.
REQ-030 Scrub address SHALL wrap from NUM_TOT_WORDS-1 to 0.
REQ-031 scrub_en_i=0 in any state SHALL force IDLE next cycle, scrub_req_o=0; scrub address retained.
REQ-032 scrub_gnt_i while scrub_req_o=0 SHALL be ignored.
REQ-033 scrub_req_o SHALL be a direct decode of state REQ (no combinational path from inputs).

Reset
REQ-034 On rst_n=0: state IDLE, scrub address 0, interval counter 0, scrub_req_o=0, err_valid_o=0, err_addr_o=0, err_port_o=0, err_cnt_o=0, err_irq_o=0.
REQ-035 Reset mid-REQ SHALL drop scrub_req_o immediately (asynchronously); in-flight grant is not logged.

Structure
REQ-036 Shared package cv32e40p_rf_err_pkg SHALL hold scrub state enum and port-code constants (PORT_A..PORT_SCRUB).
REQ-037 Scrub FSM, interval counter and address counter SHALL be sub-module cv32e40p_rf_scrub_fsm; logging stays in top.

Verification
REQ-038 rvalid_i=001, parity_ok_i=110, raddr_a_i=5 -> next cycle err_valid_o=1, err_addr_o=5, err_port_o=0, err_cnt_o=1, err_irq_o=1.
REQ-039 rvalid_i=111, parity_ok_i=000 with raddr_b_i=9 after prior log of addr 5 -> err_cnt_o +3, err_addr_o stays 5.
REQ-040 err_cnt_o=254, three simultaneous events -> err_cnt_o=255; further events keep 255.
REQ-041 scrub_en_i=1, SCRUB_INTERVAL=4, scrub_gnt_i tied 1 -> scrub_req_o pulses every 5 cycles, addresses 0,1,2..63,0; parity_ok_i[2]=0 at addr 63 -> err_port_o=3, err_addr_o=63.
REQ-042 err_clr_i=1 same cycle as port-B event at addr 12 -> err_cnt_o=1, err_addr_o=12, err_port_o=1.
REQ-043 scrub_gnt_i withheld 10 cycles in REQ, then scrub_en_i=0 -> scrub_addr_o stable throughout, FSM IDLE next cycle, no address increment.
